// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: FSM states, register-zero
// constant, flush-length limit and the load-use match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MD_WAIT = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO         = 5'd0;
    localparam int unsigned FLUSH_CYCLES_MAX = 4;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating performance counter with increment enable and synchronous clear.
module hazard_perf_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall, branch flush, optional mul/div hold.
// Define HAZARD_MULDIV_EN to add the mul/div ports, MD_WAIT state and ex_hold.
module hazard_control_unit #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_if_id,
    input  logic [4:0]       rs2_if_id,
    input  logic [4:0]       rd_id_ex,
    input  logic             mem_read_id_ex,
    input  logic             reg_write_id_ex,
    input  logic             branch_taken_ex,
`ifdef HAZARD_MULDIV_EN
    input  logic             muldiv_start_id_ex,
    input  logic             muldiv_done,
`endif
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_hold,
    output logic [CNT_W-1:0] stall_count
);

    import hazard_pkg::*;

    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;
    logic       unused_reg_write;

    // Hazard detection only needs mem_read; reg_write is carried for interface compatibility.
    assign unused_reg_write = reg_write_id_ex;
    assign load_use = load_use_hit(mem_read_id_ex, rd_id_ex, rs1_if_id, rs2_if_id);

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
`ifdef HAZARD_MULDIV_EN
        ex_hold     = 1'b0;
`endif
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (branch_taken_ex) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = RELOAD;
                        end
`ifdef HAZARD_MULDIV_EN
                    end else if (muldiv_start_id_ex) begin
                        state_d = MD_WAIT;
`endif
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                FLUSH: begin
                    // Load-use is ignored here: the IF/ID instruction is being discarded.
                    if_id_flush = 1'b1;
                    if (branch_taken_ex) begin
                        id_ex_flush = 1'b1;
                        cnt_d       = RELOAD;
                    end else if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
`ifdef HAZARD_MULDIV_EN
                MD_WAIT: begin
                    if (muldiv_done) begin
                        state_d = RUN;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        ex_hold     = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifndef HAZARD_MULDIV_EN
    assign ex_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    hazard_perf_counter #(
        .CNT_W(CNT_W)
    ) u_stall_counter (
        .clk  (clk),
        .clr  (rst),
        .inc  (~pc_write),
        .count(stall_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized bench for hazard_control_unit: two instances (FLUSH_CYCLES=1/CNT_W=16
// and FLUSH_CYCLES=3/CNT_W=4) against a cycle-level reference model plus directed pins.
module tb_hazard_control_unit;

`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       mem_read, reg_write, branch, md_start, md_done;

    logic        pc_a, ifw_a, iff_a, idf_a, hold_a;
    logic        pc_b, ifw_b, iff_b, idf_b, hold_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .rs1_if_id(rs1), .rs2_if_id(rs2), .rd_id_ex(rd),
        .mem_read_id_ex(mem_read), .reg_write_id_ex(reg_write), .branch_taken_ex(branch),
`ifdef HAZARD_MULDIV_EN
        .muldiv_start_id_ex(md_start), .muldiv_done(md_done),
`endif
        .pc_write(pc_a), .if_id_write(ifw_a), .if_id_flush(iff_a), .id_ex_flush(idf_a),
        .ex_hold(hold_a), .stall_count(cnt_a)
    );

    hazard_control_unit #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .rs1_if_id(rs1), .rs2_if_id(rs2), .rd_id_ex(rd),
        .mem_read_id_ex(mem_read), .reg_write_id_ex(reg_write), .branch_taken_ex(branch),
`ifdef HAZARD_MULDIV_EN
        .muldiv_start_id_ex(md_start), .muldiv_done(md_done),
`endif
        .pc_write(pc_b), .if_id_write(ifw_b), .if_id_flush(iff_b), .id_ex_flush(idf_b),
        .ex_hold(hold_b), .stall_count(cnt_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flush_left = further cycles of forced if_id_flush,
    // busy = mul/div outstanding, stalls = saturating count of pc_write=0 cycles.
    int fc[2]   = '{1, 3};
    int cmax[2] = '{65535, 15};
    int flush_left[2] = '{0, 0};
    bit busy[2] = '{0, 0};
    int stalls[2] = '{0, 0};

    always @(negedge clk) begin
        bit lu;
        int e_pc, e_ifw, e_iff, e_idf, e_hold;
        int a_pc, a_ifw, a_iff, a_idf, a_hold, a_cnt;
        lu = mem_read && rd != 5'd0 && (rd == rs1 || rd == rs2);
        for (int k = 0; k < 2; k++) begin
            e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0;
            if (rst) begin
                e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
            end else if (busy[k]) begin
                if (!md_done) begin e_pc = 0; e_ifw = 0; e_hold = 1; end
            end else if (flush_left[k] > 0) begin
                e_iff = 1;
                e_idf = branch ? 1 : 0;
            end else if (branch) begin
                e_iff = 1; e_idf = 1;
            end else if (md_start) begin
                e_pc = 1;
            end else if (lu) begin
                e_pc = 0; e_ifw = 0; e_idf = 1;
            end
            if (k == 0) begin
                a_pc = int'(pc_a); a_ifw = int'(ifw_a); a_iff = int'(iff_a);
                a_idf = int'(idf_a); a_hold = int'(hold_a); a_cnt = int'(cnt_a);
            end else begin
                a_pc = int'(pc_b); a_ifw = int'(ifw_b); a_iff = int'(iff_b);
                a_idf = int'(idf_b); a_hold = int'(hold_b); a_cnt = int'(cnt_b);
            end
            chk($sformatf("model%0d pc_write", k), a_pc, e_pc);
            chk($sformatf("model%0d if_id_write", k), a_ifw, e_ifw);
            chk($sformatf("model%0d if_id_flush", k), a_iff, e_iff);
            chk($sformatf("model%0d id_ex_flush", k), a_idf, e_idf);
            chk($sformatf("model%0d ex_hold", k), a_hold, e_hold);
            if (!$isunknown(cnt_a) || k == 1)
                chk($sformatf("model%0d stall_count", k), a_cnt, stalls[k]);

            if (rst) begin
                flush_left[k] = 0; busy[k] = 0; stalls[k] = 0;
            end else begin
                if (e_pc == 0 && stalls[k] < cmax[k]) stalls[k]++;
                if (busy[k]) begin
                    if (md_done) busy[k] = 0;
                end else if (flush_left[k] > 0) begin
                    flush_left[k] = branch ? fc[k] - 1 : flush_left[k] - 1;
                end else if (branch) begin
                    flush_left[k] = fc[k] - 1;
                end else if (md_start) begin
                    busy[k] = 1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rst = 0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        mem_read = 0; reg_write = 0; branch = 0; md_start = 0; md_done = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        #3;
        chk("reset pc_write", int'(pc_a), 0);
        chk("reset if_id_flush", int'(iff_b), 1);
        chk("reset id_ex_flush", int'(idf_a), 1);
        cyc(); cyc();
        chk("reset stall_count", int'(cnt_a), 0);

        cyc(); idle(); #1;
        chk("post-reset pc_write", int'(pc_a), 1);
        chk("post-reset if_id_flush", int'(iff_b), 0);

        // lw x5 followed by a consumer of x5
        cyc(); mem_read = 1; reg_write = 1; rd = 5'd5; rs1 = 5'd5; #1;
        chk("load-use pc_write", int'(pc_a), 0);
        chk("load-use if_id_write", int'(ifw_b), 0);
        chk("load-use id_ex_flush", int'(idf_a), 1);
        cyc(); idle(); #1;
        chk("load-use one bubble", int'(pc_a), 1);
        chk("load-use stall_count", int'(cnt_a), 1);

        cyc(); mem_read = 1; rd = 5'd0; rs1 = 5'd0; #1;
        chk("x0 load no stall", int'(pc_a), 1);
        chk("x0 load no flush", int'(idf_b), 0);

        // branch coinciding with load-use: flush wins
        cyc(); branch = 1; mem_read = 1; rd = 5'd5; rs1 = 5'd5; #1;
        chk("branch+lu pc_write", int'(pc_b), 1);
        chk("branch+lu if_id_flush", int'(iff_b), 1);
        chk("branch+lu id_ex_flush", int'(idf_b), 1);
        cyc(); idle(); #1;
        chk("flush3 cycle2 if_id_flush", int'(iff_b), 1);
        chk("flush3 cycle2 id_ex_flush", int'(idf_b), 0);
        chk("flush1 done", int'(iff_a), 0);
        cyc(); #1;
        chk("flush3 cycle3 if_id_flush", int'(iff_b), 1);
        cyc(); #1;
        chk("flush3 ended", int'(iff_b), 0);
        chk("flush stall_count", int'(cnt_b), 1);

        if (MD_EN) begin
            cyc(); md_start = 1; #1;
            chk("md start defaults", int'(pc_a), 1);
            for (int i = 0; i < 4; i++) begin
                cyc(); md_start = 0; #1;
                chk("md wait ex_hold", int'(hold_a), 1);
                chk("md wait pc_write", int'(pc_b), 0);
            end
            cyc(); md_done = 1; #1;
            chk("md done ex_hold", int'(hold_a), 0);
            chk("md done pc_write", int'(pc_a), 1);
            cyc(); idle(); #1;
            chk("md stall_count", int'(cnt_a), 5);
            cyc(); md_start = 1;
            cyc(); md_start = 0;
            cyc(); #1;
            chk("md mid hold", int'(hold_b), 1);
        end

        cyc(); rst = 1;
        cyc(); idle(); #1;
        chk("reset release hold", int'(hold_a), 0);
        chk("reset release pc", int'(pc_b), 1);
        chk("reset release count", int'(cnt_b), 0);

        // 20 back-to-back load-use stalls saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            cyc(); mem_read = 1; rd = 5'd7; rs2 = 5'd7;
        end
        cyc(); idle(); #1;
        chk("sat 4-bit count", int'(cnt_b), 15);
        chk("16-bit count", int'(cnt_a), 20);

        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst       = ($urandom_range(0, 63) == 0);
            rs1       = 5'($urandom_range(0, 3));
            rs2       = 5'($urandom_range(0, 3));
            rd        = 5'($urandom_range(0, 3));
            mem_read  = ($urandom_range(0, 1) == 1);
            reg_write = ($urandom_range(0, 1) == 1);
            branch    = ($urandom_range(0, 7) == 0);
            md_start  = MD_EN && ($urandom_range(0, 15) == 0);
            md_done   = MD_EN && ($urandom_range(0, 5) == 0);
        end
        cyc(); idle();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, meaning cycles (1..4) that if_id_flush is held after a taken branch.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the stall performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rs1_if_id, rs2_if_id  in  5  source registers of the instruction in IF/ID.
REQ-006 rd_id_ex  in  5  destination register of the instruction in ID/EX.
REQ-007 mem_read_id_ex, reg_write_id_ex  in  1  the ID/EX instruction is a load / writes rd.
REQ-008 branch_taken_ex  in  1  a taken branch or jump resolved in EX this cycle.
REQ-009 muldiv_start_id_ex  in  1  a multi-cycle mul/div op enters EX (MULDIV_EN only).
REQ-010 muldiv_done  in  1  single-cycle pulse; mul/div result is valid (MULDIV_EN only).
REQ-011 pc_write, if_id_write  out  1  enable PC and IF/ID updates.
REQ-012 if_id_flush, id_ex_flush  out  1  replace IF/ID or ID/EX contents with a bubble.
REQ-013 ex_hold  out  1  freeze ID/EX and EX/MEM while mul/div busy.
REQ-014 stall_count  out  CNT_W  count of cycles with pc_write=0.

Function
REQ-015 SHALL implement FSM states RUN, FLUSH, MD_WAIT; outputs are Mealy (combinational from registered state and current inputs).
REQ-016 Default outputs: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0, ex_hold=0.
REQ-017 Priority in RUN: branch_taken_ex > muldiv_start_id_ex > load-use.
REQ-018 Load-use in RUN: mem_read_id_ex && rd_id_ex!=0 && (rd_id_ex==rs1_if_id || rd_id_ex==rs2_if_id) -> pc_write=0, if_id_write=0, id_ex_flush=1 in the same cycle; state stays RUN; single-cycle bubble.
REQ-019 Load-use with rd_id_ex==0, or with mem_read_id_ex=0, SHALL NOT stall.
REQ-020 Taken branch in RUN: if_id_flush=1, id_ex_flush=1, pc_write=1 in the same cycle; if FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1, else stay RUN.
REQ-021 In FLUSH: if_id_flush=1, load-use detection suppressed; decrement counter each cycle; return to RUN in the cycle after the counter reaches 1.
REQ-022 branch_taken_ex in FLUSH SHALL reload the counter to FLUSH_CYCLES-1 and assert id_ex_flush.
REQ-023 muldiv_start_id_ex in RUN -> MD_WAIT next cycle; in the start cycle outputs are default.
REQ-024 In MD_WAIT: pc_write=0, if_id_write=0, ex_hold=1, no flushes; branch_taken_ex and load-use ignored.
REQ-025 muldiv_done in MD_WAIT -> all outputs default in that cycle, RUN next cycle; muldiv_done outside MD_WAIT ignored.
REQ-026 stall_count increments by 1 each cycle pc_write=0 and saturates at all-ones (no wrap).

Reset
REQ-027 While rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, ex_hold=0.
REQ-028 Reset SHALL force state=RUN, flush counter=0, stall_count=0, including mid-FLUSH or mid-MD_WAIT; the first cycle after reset shows default outputs.

Configuration
REQ-029 Macro HAZARD_MULDIV_EN defined: muldiv ports, MD_WAIT state, and ex_hold logic present.
REQ-030 Macro HAZARD_MULDIV_EN undefined: muldiv ports absent, MD_WAIT not generated, ex_hold tied 0, all other behaviour unchanged.

Structure
REQ-031 Shared package hazard_pkg SHALL hold the state enum (RUN, FLUSH, MD_WAIT), REG_ZERO=5'd0, and the FLUSH_CYCLES legal maximum (4).
REQ-032 Sub-module hazard_perf_counter (saturating CNT_W counter with increment enable and sync clear) SHALL implement stall_count.

Verification
REQ-033 lw x5 in ID/EX (rd=5, mem_read=1), rs1_if_id=5 -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1.
REQ-034 rd_id_ex=0 with mem_read=1, rs1_if_id=0 -> no stall, outputs default.
REQ-035 FLUSH_CYCLES=3, branch_taken_ex pulse -> if_id_flush high 3 cycles, id_ex_flush high 1 cycle, pc_write stays 1.
REQ-036 Branch and load-use in the same cycle -> flush only, pc_write=1, no stall.
REQ-037 HAZARD_MULDIV_EN: start, done 5 cycles later -> ex_hold=1 and pc_write=0 for 4 cycles, stall_count=4; rst mid-wait -> RUN, stall_count=0.
REQ-038 stall_count with CNT_W=4 after 20 stalled cycles -> holds 4'hF.
